io_button_hex_ctrl: RTL and testbench
=====================================

Name: io_button_hex_ctrl

Overview:
Memory-mapped I/O peripheral for the ARM single-cycle core. It replaces the fixed single-button, two-digit hex wiring with parametrised N-button debounce and sticky press-event capture, plus an N-digit seven-segment driver. It sits on the data-memory bus beside dmem, and computer_top decodes its address window.

Parameters:
N_BTN, 4, number of raw button inputs (1..8)
N_DIGITS, 4, number of seven-segment digits driven (1..8)
DEBOUNCE_CYCLES, 4, synchronized cycles a new level must persist before acceptance (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_n  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous to clk
addr  in  5  byte address in peripheral window; addr[1:0] ignored
we  in  1  write strobe, sampled at rising clk
wdata  in  32  write data
rdata  out  32  read data, combinational from addr
hex_seg  out  7*N_DIGITS  active-low segments, digit i at [7i+6:7i], seg order g..a
irq  out  1  |(BTN_EVENT & {N_BTN{CTRL.irq_en}})

Behaviour:
- Register map (word offsets): 0x00 BTN_LEVEL (RO, debounced level, 1 = released); 0x04 BTN_EVENT (sticky press flags, write-1-to-clear); 0x08 HEX_VALUE (RW, nibble i -> digit i; bits above 4*N_DIGITS read 0); 0x0C CTRL (bit0 disp_en, bit1 irq_en, others read 0); unmapped offsets read 0 and ignore writes.
- Reset values: sync flops all 1; debounce counters 0; BTN_LEVEL all 1; BTN_EVENT 0; HEX_VALUE 0; CTRL = 0x1; hex_seg = 7'b1000000 per digit; irq 0. Reset mid-debounce discards partial counts.
- Per button: 2-flop synchronizer then counter. While sync output equals level, counter = 0. While they differ, counter increments each edge. At the edge where the counter == DEBOUNCE_CYCLES-1 and the mismatch persists, level flips and the counter clears.
- Latency: a raw change first sampled at edge k appears on BTN_LEVEL at edge k+DEBOUNCE_CYCLES+1. With the default of 4, that is the 6th edge counting edge k as 1.
- Glitch rule: a change lasting fewer than DEBOUNCE_CYCLES synchronized cycles never reaches BTN_LEVEL.
- A level 1->0 transition sets BTN_EVENT[i] at the same edge. Release does not set it.
- A write to 0x04 clears bits where wdata=1. A set and a clear on the same bit in the same cycle leaves it set.
- hex_seg is registered: one cycle after a HEX_VALUE or CTRL write, it shows the hex glyphs 0-F (0 = 7'b1000000, F = 7'b0001110). When disp_en = 0, all segments = 1 (blank).
- irq is combinational from registered state. It has no pulse semantics.

Optional Feature:
PRESS_COUNT_EN:
- Defined: adds register 0x10 PRESS_COUNT, byte i = 8-bit count of BTN_EVENT set-conditions for button i (i < min(N_BTN,4)). Each byte increments on every press, including when the event bit is already set. It wraps 255 -> 0. Any write to 0x10 clears all counts; a press in the same cycle as that write yields count 1. Reset value is 0.
- Undefined: 0x10 reads 0, writes are ignored, and no counter logic is instantiated.

Test Plan:
- Reset held, btn_n toggling -> rdata@0x00 = 0xF, @0x04 = 0, @0x0C = 0x1, hex_seg = {4{7'b1000000}}, irq = 0; after release, same values until a button is stable 6 edges.
- btn_n[2] low for 10 cycles (default params) -> BTN_LEVEL = 0xB exactly on the 6th edge after first sample; BTN_EVENT = 0x4; irq stays 0 until CTRL written 0x3, then 1.
- btn_n[0] low for 3 cycles, high, repeated 5 times -> BTN_LEVEL stays 0xF, BTN_EVENT stays 0.
- BTN_EVENT = 0x4, write 0x04 <= 0x4 in the same cycle btn 2 level falls again -> BTN_EVENT remains 0x4. A later write of 0x4 with no press -> 0x0, irq 0.
- Write HEX_VALUE <= 0x0000F3A0 -> next cycle hex_seg digits 3..0 = F,3,A,0 glyphs. Write CTRL <= 0x0 -> next cycle all 28 bits 1.
- PRESS_COUNT_EN: 257 debounced presses on btn 1 -> rdata@0x10 = 0x00000100. Write 0x10 -> 0.

Source files
------------

// File: rtl/io_button_hex_ctrl.sv
// Memory-mapped button/seven-segment peripheral: N-button debounce with sticky press events,
// N-digit hex display driver. Define PRESS_COUNT_EN to add the per-button press counter at 0x10.
module io_button_hex_ctrl #(
    parameter int N_BTN           = 4,
    parameter int N_DIGITS        = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      btn_n,
    input  logic [4:0]            addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [7*N_DIGITS-1:0] hex_seg,
    output logic                  irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int              NP       = (N_BTN < 4) ? N_BTN : 4;

    logic [N_BTN-1:0]      sync1, sync2, level, btn_event, press, clr;
    logic [CW-1:0]         cnt [N_BTN];
    logic [4*N_DIGITS-1:0] hex_value;
    logic [1:0]            ctrl;
    logic [2:0]            sel;
    logic                  unused_ok;

    assign sel       = addr[4:2];
    assign unused_ok = &{1'b0, addr[1:0], wdata};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // A press is the edge at which a debounced level is about to fall to 0.
    always_comb begin
        press = '0;
        for (int i = 0; i < N_BTN; i++)
            press[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_LAST) && !sync2[i];
    end

    assign clr = (we && sel == 3'd1) ? wdata[N_BTN-1:0] : '0;
    assign irq = |(btn_event & {N_BTN{ctrl[1]}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Set wins over write-1-to-clear so a press coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_event <= '0;
            hex_value <= '0;
            ctrl      <= 2'b01;
        end else begin
            btn_event <= (btn_event & ~clr) | press;
            if (we && sel == 3'd2) hex_value <= wdata[4*N_DIGITS-1:0];
            if (we && sel == 3'd3) ctrl <= wdata[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_seg <= {N_DIGITS{7'b1000000}};
        end else begin
            for (int d = 0; d < N_DIGITS; d++)
                hex_seg[7*d +: 7] <= ctrl[0] ? glyph(hex_value[4*d +: 4]) : 7'b1111111;
        end
    end

`ifdef PRESS_COUNT_EN
    logic [7:0] press_cnt [NP];
    logic       cnt_clr;

    assign cnt_clr = we && (sel == 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NP; j++) press_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NP; j++) begin
                if (cnt_clr)
                    press_cnt[j] <= press[j] ? 8'd1 : 8'd0;
                else if (press[j])
                    press_cnt[j] <= press_cnt[j] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0: rdata[N_BTN-1:0]      = level;
            3'd1: rdata[N_BTN-1:0]      = btn_event;
            3'd2: rdata[4*N_DIGITS-1:0] = hex_value;
            3'd3: rdata[1:0]            = ctrl;
`ifdef PRESS_COUNT_EN
            3'd4: for (int j = 0; j < NP; j++) rdata[8*j +: 8] = press_cnt[j];
`endif
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_button_hex_ctrl.sv
// Directed self-checking bench for io_button_hex_ctrl (default parameters); expected values
// are queued on a scoreboard and popped when the DUT output is sampled. Honours PRESS_COUNT_EN.
module tb_io_button_hex_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_n;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [27:0] hex_seg;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;

    always #5 clk = ~clk;

    io_button_hex_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (btn_n),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .hex_seg (hex_seg),
        .irq     (irq)
    );

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        expect_val(tag, exp);
        addr = a;
        #1;
        check_output(rdata);
    endtask

    task automatic seg_check(input string tag, input logic [27:0] exp);
        expect_val(tag, {4'h0, exp});
        #1;
        check_output({4'h0, hex_seg});
    endtask

    task automatic irq_check(input string tag, input logic exp);
        expect_val(tag, {31'h0, exp});
        #1;
        check_output({31'h0, irq});
    endtask

    task automatic apply_stimulus(input logic [4:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        btn_n = 4'hF;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;

        // Reset held while buttons bounce around
        repeat (6) begin
            @(negedge clk);
            btn_n = 4'($urandom_range(0, 15));
        end
        read_check("rst_level", 5'h00, 32'hF);
        read_check("rst_event", 5'h04, 32'h0);
        read_check("rst_ctrl",  5'h0C, 32'h1);
        read_check("rst_hex",   5'h08, 32'h0);
        seg_check("rst_seg", {4{G0}});
        irq_check("rst_irq", 1'b0);
        btn_n = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(8);
        read_check("post_rst_level", 5'h00, 32'hF);
        read_check("post_rst_event", 5'h04, 32'h0);

        // Short glitches on button 0 never get through
        repeat (5) begin
            btn_n[0] = 1'b0;
            tick(3);
            btn_n[0] = 1'b1;
            tick(3);
        end
        tick(6);
        read_check("glitch_level", 5'h00, 32'hF);
        read_check("glitch_event", 5'h04, 32'h0);

        // Button 2 press: exact debounce latency, event, irq gating
        btn_n[2] = 1'b0;
        tick(5);
        read_check("lat_edge5_level", 5'h00, 32'hF);
        tick(1);
        read_check("lat_edge6_level", 5'h00, 32'hB);
        read_check("lat_event", 5'h04, 32'h4);
        irq_check("irq_masked", 1'b0);
        apply_stimulus(5'h0C, 32'h3);
        irq_check("irq_enabled", 1'b1);
        read_check("ctrl_rb", 5'h0C, 32'h3);
        tick(4);
        btn_n[2] = 1'b1;
        tick(7);
        read_check("release_level", 5'h00, 32'hF);
        read_check("release_event", 5'h04, 32'h4);

        // Clear colliding with a fresh press keeps the flag
        btn_n[2] = 1'b0;
        tick(5);
        apply_stimulus(5'h04, 32'h4);
        read_check("collide_level", 5'h00, 32'hB);
        read_check("collide_event", 5'h04, 32'h4);
        apply_stimulus(5'h04, 32'h4);
        read_check("clear_event", 5'h04, 32'h0);
        irq_check("clear_irq", 1'b0);
        btn_n[2] = 1'b1;
        tick(7);
        read_check("release2_event", 5'h04, 32'h0);

        // Hex value masking, glyphs and blanking
        apply_stimulus(5'h08, 32'hFFFF_FFFF);
        read_check("hex_mask", 5'h08, 32'h0000_FFFF);
        apply_stimulus(5'h08, 32'h0000_F3A0);
        tick(1);
        seg_check("seg_f3a0", {GF, G3, GA, G0});
        apply_stimulus(5'h0C, 32'h0);
        tick(1);
        seg_check("seg_blank", 28'hFFF_FFFF);
        read_check("ctrl_zero", 5'h0C, 32'h0);
        apply_stimulus(5'h0C, 32'h1);

        // Unmapped offsets
        apply_stimulus(5'h14, 32'hFFFF_FFFF);
        read_check("unmapped_14", 5'h14, 32'h0);
        read_check("unmapped_1c", 5'h1C, 32'h0);
        read_check("hex_kept", 5'h08, 32'h0000_F3A0);
        read_check("ctrl_kept", 5'h0C, 32'h1);

        // Reset in the middle of a debounce discards the partial count
        btn_n[3] = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        read_check("midrst_level", 5'h00, 32'hF);
        seg_check("midrst_seg", {4{G0}});
        tick(5);
        read_check("midrst_edge5", 5'h00, 32'hF);
        tick(1);
        read_check("midrst_edge6", 5'h00, 32'h7);
        read_check("midrst_event", 5'h04, 32'h8);
        irq_check("midrst_irq_masked", 1'b0);
        btn_n[3] = 1'b1;
        tick(7);

`ifdef PRESS_COUNT_EN
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        read_check("pc_reset", 5'h10, 32'h0);
        for (int p = 0; p < 257; p++) begin
            btn_n[1] = 1'b0;
            tick(8);
            btn_n[1] = 1'b1;
            tick(8);
        end
        read_check("pc_257", 5'h10, 32'h0000_0100);
        apply_stimulus(5'h10, 32'h0);
        read_check("pc_clear", 5'h10, 32'h0);
        btn_n[1] = 1'b0;
        tick(5);
        apply_stimulus(5'h10, 32'h0);
        read_check("pc_clear_collide", 5'h10, 32'h0000_0100);
        btn_n[1] = 1'b1;
        tick(7);
`else
        read_check("pc_absent", 5'h10, 32'h0);
        apply_stimulus(5'h10, 32'hFFFF_FFFF);
        read_check("pc_absent_wr", 5'h10, 32'h0);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
